adder_16: RTL and testbench
===========================

ADDER_16 -- requirements
Module: adder_16

Interface
REQ-001 Parameter: RESET_VALUE, default 16'h0000, value loaded into out while reset is asserted.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock; all state SHALL update on it.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: out  output  16  registered sum.
REQ-006 Port: a  input  16  addend A, unsigned or two's complement.
REQ-007 Port: b  input  16  addend B, unsigned or two's complement.
REQ-008 Port: in_valid  input  1  qualifies a/b for capture in the current cycle.
REQ-009 Port: out_valid  output  1  high for exactly the one cycle in which out holds a new result.
REQ-010 Port order SHALL be clk, rst_n, out, a, b, in_valid, out_valid, followed by the flag ports when enabled.

Function
REQ-011 On a rising clk edge with in_valid=1, out SHALL load (a + b) mod 2^16.
REQ-012 Latency SHALL be exactly 1 cycle, from the capturing edge to out/out_valid.
REQ-013 With in_valid=0, out SHALL hold its previous value and out_valid SHALL go 0 on that edge.
REQ-014 Back-to-back in_valid=1 SHALL yield one result per cycle with no stalls or bubbles.
REQ-015 The adder SHALL be four 4-bit carry-lookahead groups (generate/propagate per bit, group G/P) chained through a second-level lookahead unit; carry-in to bit 0 SHALL be 0.
REQ-016 Sums of 2^16 or more SHALL wrap: the carry out of bit 15 is discarded from out.
REQ-017 The sum SHALL be bit-identical for unsigned and two's-complement interpretation.
REQ-018 Inputs SHALL be combinationally sampled only at the capturing edge; a/b changes between edges SHALL have no effect on out.

Reset
REQ-019 While rst_n=0: out=RESET_VALUE, out_valid=0, cout=0, ovf=0, independent of clk.
REQ-020 Reset asserted mid-operation SHALL discard any result in flight; the first edge after deassertion with in_valid=1 SHALL produce a normal result one cycle later.
REQ-021 Reset deassertion SHALL be synchronised by the integrator, not inside this block.

Configuration
REQ-022 Macro ADDER_16_FLAGS_EN SHALL control the status-flag feature.
REQ-023 With ADDER_16_FLAGS_EN defined, the block SHALL have output cout (1 bit, registered carry out of bit 15) and output ovf (1 bit, registered signed overflow = (a[15]==b[15]) && (sum[15]!=a[15])).
REQ-024 cout and ovf SHALL update on the same edges and with the same latency as out.
REQ-025 With ADDER_16_FLAGS_EN undefined, cout and ovf SHALL be absent, with no other behavioural change.

Verification
REQ-026 a=16'hCB00, b=16'h1995, in_valid=1 -> next cycle out=16'hE495, out_valid=1, cout=0, ovf=0.
REQ-027 a=16'h0000, b=16'h1995 -> out=16'h1995, then a=16'hCBF0, b=16'h0001 -> out=16'hCBF1.
REQ-028 a=16'hCB1F, b=16'h1F95 -> out=16'hEAB4, cout=0, ovf=0.
REQ-029 a=16'hFFFF, b=16'h0001 -> out=16'h0000, cout=1, ovf=0; a=16'h7FFF, b=16'h0001 -> out=16'h8000, cout=0, ovf=1.
REQ-030 Drive rst_n=0 between clock edges while out=16'hE495 -> out=RESET_VALUE and out_valid=0 immediately, before the next edge.
REQ-031 in_valid=0 while a/b toggle randomly for 5 cycles -> out is held and out_valid=0 throughout.

Source files
------------

// File: rtl/adder_16.sv
// adder_16: registered 16-bit adder built from four 4-bit carry-lookahead
// groups joined by a second-level lookahead unit. One cycle of latency.
// Optional status flags (cout, ovf) are compiled in when ADDER_16_FLAGS_EN
// is defined; without it the block has no flag ports.
module adder_16 #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        out_valid
`ifdef ADDER_16_FLAGS_EN
    ,
    output logic        cout,
    output logic        ovf
`endif
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;
    logic [15:0] sum;

    assign g = a & b;
    assign p = a ^ b;

    // Per-group generate/propagate and in-group carries from the group carry-in.
    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;

        assign gg[k] = g[B+3]
                     | (p[B+3] & g[B+2])
                     | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[k] = &p[B +: 4];

        assign c[B]   = gc[k];
        assign c[B+1] = g[B] | (p[B] & gc[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[k]);
    end

    // Second-level lookahead: carry into each group; carry-in to bit 0 is 0.
    assign gc[0] = 1'b0;
    assign gc[1] = gg[0];
    assign gc[2] = gg[1] | (gp[1] & gg[0]);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]);

    assign sum = p ^ c;

`ifdef ADDER_16_FLAGS_EN
    logic carry_msb;
    logic ovf_nxt;

    assign carry_msb = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                     | (gp[3] & gp[2] & gp[1] & gg[0]);
    assign ovf_nxt   = (a[15] == b[15]) && (sum[15] != a[15]);

    // Flags share the capture qualifier and latency of the sum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            cout <= carry_msb;
            ovf  <= ovf_nxt;
        end
    end
`else
    // Group-3 G/P only feed the carry out of bit 15, which is dropped here.
    logic unused_msb_gp;
    assign unused_msb_gp = gg[3] ^ gp[3];
`endif

    // Result register: load on in_valid, otherwise hold; valid pulses one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= RESET_VALUE;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= sum;
            end
        end
    end

endmodule

// File: tb/tb_adder_16.sv
// Self-checking bench for adder_16 with a scoreboard queue of expected
// results. Flag checks are compiled in alongside ADDER_16_FLAGS_EN.
module tb_adder_16;

    localparam logic [15:0] RV = 16'h5A3C;

    typedef struct packed {
        logic [15:0] sum;
        logic        cy;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] out;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        out_valid;
`ifdef ADDER_16_FLAGS_EN
    logic        cout;
    logic        ovf;
`endif

    exp_t        sb[$];
    logic [15:0] last_out;
    int          total;
    int          bad;

    adder_16 #(.RESET_VALUE(RV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .out       (out),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out_valid (out_valid)
`ifdef ADDER_16_FLAGS_EN
        ,
        .cout      (cout),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        exp_t e;
        s = {1'b0, x} + {1'b0, y};
        e.sum = s[15:0];
        e.cy  = s[16];
        e.ov  = (x[15] == y[15]) && (s[15] != x[15]);
        return e;
    endfunction

    task automatic check_flags_reset();
`ifdef ADDER_16_FLAGS_EN
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    endtask

    // Drive one cycle, then check what the capturing edge produced.
    task automatic step(input logic [15:0] ta, input logic [15:0] tb_, input logic tv);
        exp_t e;
        @(negedge clk);
        a        = ta;
        b        = tb_;
        in_valid = tv;
        if (tv) sb.push_back(model(ta, tb_));
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, tv});
        if (out_valid) begin
            chk("sb_size", sb.size(), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sum", {16'd0, out}, {16'd0, e.sum});
`ifdef ADDER_16_FLAGS_EN
                chk("cout", {31'd0, cout}, {31'd0, e.cy});
                chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
                last_out = e.sum;
            end
        end else begin
            chk("hold", {16'd0, out}, {16'd0, last_out});
        end
        // Disturb inputs mid-cycle; only the next edge may sample them.
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        last_out = RV;
        rst_n    = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        in_valid = 1'b0;

        #12;
        chk("rst_out", {16'd0, out}, {16'd0, RV});
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        check_flags_reset();
        #5;
        rst_n = 1'b1;

        step(16'hCB00, 16'h1995, 1'b1);
        chk("vec_e495", {16'd0, out}, 32'h0000E495);

        // Asynchronous reset between edges, with a result in flight.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", {16'd0, out}, {16'd0, RV});
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check_flags_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("in_rst_out", {16'd0, out}, {16'd0, RV});
        chk("in_rst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        last_out = RV;

        step(16'h1234, 16'h4321, 1'b1);
        step(16'h0000, 16'h1995, 1'b1);
        step(16'hCBF0, 16'h0001, 1'b1);
        chk("vec_cbf1", {16'd0, out}, 32'h0000CBF1);
        step(16'hCB1F, 16'h1F95, 1'b1);
        chk("vec_eab4", {16'd0, out}, 32'h0000EAB4);
        step(16'hFFFF, 16'h0001, 1'b1);
        chk("vec_wrap", {16'd0, out}, 32'h00000000);
        step(16'h7FFF, 16'h0001, 1'b1);
        chk("vec_8000", {16'd0, out}, 32'h00008000);
        step(16'h8000, 16'h8000, 1'b1);
        step(16'hFFFF, 16'hFFFF, 1'b1);
        step(16'h00FF, 16'hFF01, 1'b1);

        for (int i = 0; i < 5; i++) step(16'($urandom), 16'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) step(16'($urandom), 16'($urandom), 1'b1);
        for (int i = 0; i < 40; i++) step(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        step(16'h0, 16'h0, 1'b0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
